uart_tx_arbiter: RTL
====================

Name: uart_tx_arbiter

Overview:
- Shares one UART transmitter (byte input, one-cycle load strobe, end-of-frame indication) among N_REQ byte producers.
- Round-robin arbitration; at most one frame in flight.
- Each granted byte goes to the transmitter with a single-cycle load; the next frame is not started until the transmitter reports frame end.
- Sits between client logic (command responders, status reporters) and the uart top-level tx_data/load/tx_stop pins.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- TIMEOUT, 65535, max cycles spent in WAIT before abort. Must exceed one frame time: 10 bits x 5208 = 52080 cycles.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous reset, active-high
- req  input  N_REQ  per-requester byte-pending flag
- req_data  input  8*N_REQ  byte of requester i at bits [8i+7:8i]
- gnt  output  N_REQ  one-hot, one-cycle pulse: byte of requester i captured
- tx_data  output  8  byte to transmitter, stable from load until frame end
- load  output  1  one-cycle start strobe to transmitter
- tx_stop  input  1  one-cycle pulse from transmitter at end of stop bit
- busy  output  1  high while a frame is owned (LOAD/WAIT)
- grant_id  output  clog2(N_REQ)  index of current/last granted requester
- timeout_err  output  1  sticky, set on WAIT timeout

Behaviour:
- Reset (rst=1 at a clk edge): state=IDLE, gnt=0, load=0, tx_data=0, busy=0, grant_id=0, timeout_err=0, rr pointer=0, timer=0. Reset mid-frame abandons the frame; no gnt/load is issued in the reset cycle.
- States: IDLE, WAIT. All outputs are registered.
- IDLE: if any req bit is set, choose the winner as the first set bit scanning from ptr upward with wrap (ptr, ptr+1, ..., N_REQ-1, 0, ...). On that edge:
  - tx_data <= req_data[winner]
  - gnt[winner] <= 1, load <= 1, busy <= 1
  - grant_id <= winner, ptr <= (winner+1) mod N_REQ
  - timer <= 0, state <= WAIT
  - If no req is set, stay in IDLE with all strobes low.
- Latency: req sampled high at edge k gives gnt and load high during cycle k+1, for exactly one cycle.
- WAIT:
  - gnt and load return to 0 after one cycle.
  - tx_stop is ignored in the first WAIT cycle (the cycle where load=1).
  - From the second WAIT cycle on, tx_stop=1 sends state to IDLE and sets busy=0 on that edge.
  - Earliest next load is 2 cycles after the tx_stop pulse.
- Timeout: timer increments each WAIT cycle. If timer reaches TIMEOUT-1 without tx_stop:
  - timeout_err <= 1, sticky until rst
  - state <= IDLE, busy <= 0
  - The byte counts as delivered; no re-grant.
- tx_stop and timeout in the same cycle: tx_stop wins, timeout_err is not set.
- Requester contract:
  - Hold req and req_data stable until gnt.
  - req still high in the cycle after gnt means another byte is pending; it re-enters arbitration normally.
  - req dropped before gnt means the request is withdrawn without error.
- Fairness: with all requesters continuously requesting, grants rotate 0,1,...,N_REQ-1,0. No requester waits more than N_REQ-1 frames.
- tx_stop pulses in IDLE are ignored.
- timer width = clog2(TIMEOUT+1); it saturates and never wraps.

Test Plan:
- Single request: reset, then req=4'b0100 with req_data[23:16]=8'hA5 at edge 10. Expect gnt=4'b0100 and load=1 in cycle 11 only, tx_data=8'hA5, grant_id=2, busy=1. tx_stop pulse at cycle 40 → busy=0 from cycle 41; no further load.
- Round-robin: req=4'b1111 held, bytes 8'h10/8'h11/8'h12/8'h13, tx_stop modelled 20 cycles after each load. Expect grant order 0,1,2,3,0 and tx_data sequence 10,11,12,13,10. Exactly one load per tx_stop.
- Pointer wrap: after a grant to requester 3, set req=4'b0011. Expect the next grant to requester 0, then 1.
- Early tx_stop: assert tx_stop in the same cycle as load. Expect it ignored and state remains WAIT; a tx_stop 5 cycles later returns to IDLE.
- Timeout: TIMEOUT=100, grant with no tx_stop. Expect timeout_err=1 and busy=0 after 100 WAIT cycles, next pending req granted. Also drive tx_stop in the exact expiry cycle and expect timeout_err to stay 0.
- Reset mid-frame: rst=1 during WAIT with req=4'b0001. Expect all outputs cleared the next cycle, and a new grant to requester 0 one cycle after rst falls.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART transmitter among N_REQ byte producers.
// One frame in flight at a time; a frame ends on tx_stop or on a WAIT timeout.
module uart_tx_arbiter #(
    parameter  int N_REQ   = 4,
    parameter  int TIMEOUT = 65535,
    localparam int IDW     = $clog2(N_REQ),
    localparam int TW      = $clog2(TIMEOUT + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_REQ-1:0]     req,
    input  logic [8*N_REQ-1:0]   req_data,
    output logic [N_REQ-1:0]     gnt,
    output logic [7:0]           tx_data,
    output logic                 load,
    input  logic                 tx_stop,
    output logic                 busy,
    output logic [IDW-1:0]       grant_id,
    output logic                 timeout_err
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    localparam logic [TW-1:0] TIMEOUT_M1 = TW'(TIMEOUT - 1);
    localparam logic [TW-1:0] TIMER_MAX  = {TW{1'b1}};

    state_t             state_r;
    logic [N_REQ-1:0]   gnt_r;
    logic [7:0]         tx_data_r;
    logic               load_r;
    logic               busy_r;
    logic [IDW-1:0]     grant_id_r;
    logic               timeout_err_r;
    logic [IDW-1:0]     ptr_r;
    logic [TW-1:0]      timer_r;

    logic               any_req_s;
    logic [IDW-1:0]     winner_s;
    logic [IDW-1:0]     ptr_next_s;
    logic [7:0]         win_data_s;

    // First set request bit scanning upward from p with wrap-around.
    function automatic logic [IDW-1:0] rr_pick(input logic [N_REQ-1:0] r,
                                               input logic [IDW-1:0]   p);
        logic [IDW-1:0] w;
        logic           f;
        logic [IDW:0]   idx;
        w = '0;
        f = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            idx = {1'b0, p} + (IDW+1)'(i);
            if (idx >= (IDW+1)'(N_REQ)) begin
                idx = idx - (IDW+1)'(N_REQ);
            end else begin
                idx = idx;
            end
            if (!f && r[idx[IDW-1:0]]) begin
                w = idx[IDW-1:0];
                f = 1'b1;
            end else begin
                w = w;
            end
        end
        return w;
    endfunction

    assign any_req_s  = |req;
    assign winner_s   = rr_pick(req, ptr_r);
    assign ptr_next_s = (winner_s == IDW'(N_REQ - 1)) ? '0 : winner_s + IDW'(1);

    // Byte of the winning requester.
    always_comb begin
        win_data_s = 8'h00;
        for (int i = 0; i < N_REQ; i++) begin
            if (winner_s == IDW'(i)) begin
                win_data_s = req_data[8*i +: 8];
            end else begin
                win_data_s = win_data_s;
            end
        end
    end

    // Arbitration FSM with registered strobes, byte hold and frame timer.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= ST_IDLE;
            gnt_r         <= '0;
            tx_data_r     <= 8'h00;
            load_r        <= 1'b0;
            busy_r        <= 1'b0;
            grant_id_r    <= '0;
            timeout_err_r <= 1'b0;
            ptr_r         <= '0;
            timer_r       <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (any_req_s) begin
                        tx_data_r  <= win_data_s;
                        gnt_r      <= N_REQ'(1) << winner_s;
                        load_r     <= 1'b1;
                        busy_r     <= 1'b1;
                        grant_id_r <= winner_s;
                        ptr_r      <= ptr_next_s;
                        timer_r    <= '0;
                        state_r    <= ST_WAIT;
                    end else begin
                        gnt_r  <= '0;
                        load_r <= 1'b0;
                    end
                end
                ST_WAIT: begin
                    gnt_r  <= '0;
                    load_r <= 1'b0;
                    // load_r high marks the first WAIT cycle, where tx_stop belongs to the previous frame.
                    if (tx_stop && !load_r) begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                    end else if (timer_r == TIMEOUT_M1) begin
                        timeout_err_r <= 1'b1;
                        state_r       <= ST_IDLE;
                        busy_r        <= 1'b0;
                    end else if (timer_r != TIMER_MAX) begin
                        timer_r <= timer_r + TW'(1);
                    end else begin
                        timer_r <= timer_r;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    gnt_r   <= '0;
                    load_r  <= 1'b0;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign gnt         = gnt_r;
    assign tx_data     = tx_data_r;
    assign load        = load_r;
    assign busy        = busy_r;
    assign grant_id    = grant_id_r;
    assign timeout_err = timeout_err_r;

endmodule
